// File: rtl/iic_pkg.sv
// iic_pkg: command encodings, one-hot states and quarter indices for the I2C master
package iic_pkg;
  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam logic [3:0] LAST_BIT = 4'd8;
  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_HOLD  = 6'b000010,
    S_START = 6'b000100,
    S_WRITE = 6'b001000,
    S_READ  = 6'b010000,
    S_STOP  = 6'b100000
  } state_e;
endpackage

// File: rtl/iic_if.sv
// iic_if: command handshake between a controller and the I2C master
interface iic_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] wr_data;
  logic       rd_nack;
  logic [7:0] rd_data;
  logic       nack;
  logic       done;
  logic       err;
  logic       busy;
  modport master (input cmd_valid, cmd, wr_data, rd_nack, output cmd_ready, rd_data, nack, done, err, busy);
  modport slave (output cmd_valid, cmd, wr_data, rd_nack, input cmd_ready, rd_data, nack, done, err, busy);
endinterface

// File: rtl/iic_tick_gen.sv
// iic_tick_gen: quarter-SCL-period tick, counter parked at zero while not running
module iic_tick_gen #(
  parameter int QDIV = 125,
  parameter int QW   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);
  localparam logic [QW-1:0] LAST = QW'(QDIV - 1);
  logic [QW-1:0] cnt;
  assign tick = run && cnt == LAST;
  // count 0..QDIV-1 while the bus is active, wrap on the tick
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!run || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/iic_master.sv
// iic_master: byte-level I2C master with START/WRITE/READ/STOP command handshake
module iic_master
  import iic_pkg::*;
#(
  parameter int QDIV = 125,
  parameter int QW   = 16
) (
  input  logic clk,
  input  logic rst,
  iic_if.master bus,
  output logic iclk,
  inout  wire  sdata
);
  state_e state, state_n;
  logic tick, idle_hold, accept, illegal, cell_end, last_cell, scl_c, rel_c, sda_oe, bit_val, rdn;
  logic [1:0] q;
  logic [3:0] bit_cnt;
  logic [7:0] sh;
  assign idle_hold = state == S_IDLE || state == S_HOLD;
  assign bus.cmd_ready = idle_hold;
  assign bus.busy = !idle_hold;
  assign accept = bus.cmd_valid && idle_hold;
  assign illegal = state == S_IDLE && bus.cmd != CMD_START;
  assign cell_end = tick && q == Q3;
  assign last_cell = bit_cnt == LAST_BIT;
  assign bit_val = state == S_READ ? (last_cell ? rdn : 1'b1) : (last_cell || sh[7]);
  assign sdata = sda_oe ? 1'b0 : 1'bz;
  iic_tick_gen #(.QDIV(QDIV), .QW(QW)) u_tick (.clk(clk), .rst(rst), .run(!idle_hold), .tick(tick));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  // next state and the SCL/SDA level wanted for the current quarter
  always_comb begin
    state_n = state;
    scl_c = 1'b1;
    rel_c = 1'b1;
    if (accept && !illegal)
      state_n = bus.cmd == CMD_START ? S_START : bus.cmd == CMD_WRITE ? S_WRITE : bus.cmd == CMD_READ ? S_READ : S_STOP;
    else if (cell_end && (state == S_START || state == S_STOP || last_cell))
      state_n = state == S_STOP ? S_IDLE : S_HOLD;
    case (state)
      S_HOLD: scl_c = 1'b0;
      S_START: begin
        scl_c = q == Q0 ? iclk : q != Q3;
        rel_c = q < Q2;
      end
      S_WRITE, S_READ: begin
        scl_c = q == Q1 || q == Q2;
        rel_c = bit_val;
      end
      S_STOP: begin
        scl_c = q != Q0;
        rel_c = q >= Q2;
      end
      default: ;
    endcase
  end
  // quarter/bit sequencing, shift register, pin drivers and result registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= Q0;
      bit_cnt <= '0;
      sh <= '0;
      rdn <= 1'b0;
      iclk <= 1'b1;
      sda_oe <= 1'b0;
      bus.rd_data <= '0;
      bus.nack <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      iclk <= scl_c;
      sda_oe <= !rel_c;
      bus.done <= state_n != state && (state_n == S_HOLD || state_n == S_IDLE);
      bus.err <= accept && illegal;
      if (accept) begin
        q <= Q0;
        bit_cnt <= '0;
        sh <= bus.wr_data;
        rdn <= bus.rd_nack;
      end else if (tick) begin
        q <= q + 1'b1;
        if (q == Q2 && (state == S_READ ? !last_cell : state == S_WRITE && last_cell)) sh <= {sh[6:0], sdata};
        if (q == Q3) bit_cnt <= bit_cnt + 1'b1;
        if (q == Q3 && state == S_WRITE && !last_cell) sh <= {sh[6:0], 1'b0};
      end
      if (cell_end && last_cell && state == S_WRITE) bus.nack <= sh[0];
      if (cell_end && last_cell && state == S_READ) bus.rd_data <= sh;
    end
endmodule

// File: tb/tb_iic_master.sv
// tb_iic_master: scoreboard bench with an I2C slave model and bus-condition monitor
module tb_iic_master;
  import iic_pkg::*;
  localparam int QDIV = 4;
  typedef struct {
    logic       is_err;
    logic [1:0] cmd;
    logic [7:0] rd;
    logic       nk;
    int         acc, lat, starts, stops, rises;
  } exp_t;
  logic clk = 0, rst = 1, iclk, slv_low = 0;
  wire sdata;
  iic_if bus();
  assign sdata = slv_low ? 1'b0 : 1'bz;
  pullup (sdata);
  iic_master #(.QDIV(QDIV), .QW(16)) dut (.clk(clk), .rst(rst), .bus(bus), .iclk(iclk), .sdata(sdata));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, passes = 0;
  exp_t exp_q[$];
  int seq = 0, slv_mode = 0, e_start = 0, e_stop = 0, e_rise = 0;
  logic [7:0] slv_byte = 0;
  logic slv_ack = 0, slv_rdn = 0, owned = 0;
  int n_start, n_stop, n_rise, rx_n, k, seen;
  logic [8:0] rx;
  logic pscl, psda, pdone, perr;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // what the slave pulls low for cell kk of the current byte
  function automatic logic slave_bit(input int mode, input int kk);
    if (mode == 1) return kk == 8 && slv_ack;
    if (mode == 2) return kk < 8 && !slv_byte[7 - kk];
    return 1'b0;
  endfunction

  // bus monitor, slave model and done/err scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      slv_low = 0; k = 0; rx_n = 0; rx = 0;
      n_start = 0; n_stop = 0; n_rise = 0;
      pscl = iclk; psda = sdata; seen = seq; pdone = 0; perr = 0;
    end else begin
      if (seq != seen) begin
        seen = seq; k = 0; rx_n = 0; rx = 0;
        slv_low = slave_bit(slv_mode, 0);
      end
      if (pscl && iclk && psda != sdata) begin
        if (sdata) n_stop++;
        else n_start++;
      end
      if (!pscl && iclk) begin
        n_rise++;
        rx = {rx[7:0], sdata};
        rx_n++;
        if (slv_mode == 1 && rx_n == 8) chk("wr_bits_on_bus", int'(rx[7:0]), int'(slv_byte));
        if (slv_mode == 2 && rx_n == 9) chk("rd_master_ack_bit", int'(sdata), int'(slv_rdn));
      end
      if (pscl && !iclk && slv_mode != 0) begin
        k++;
        slv_low = slave_bit(slv_mode, k);
      end
      pscl = iclk;
      psda = sdata;
      if (bus.done) chk("done_one_cycle", int'(pdone), 0);
      if (bus.err) chk("err_one_cycle", int'(perr), 0);
      if (bus.done || bus.err) begin
        chk("response_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("err_vs_done", int'(bus.err), int'(e.is_err));
          chk("latency", cyc - e.acc, e.lat);
          chk("scl_rises", n_rise, e.rises);
          if (!e.is_err) begin
            chk("ready_at_done", int'(bus.cmd_ready), 1);
            chk("busy_at_done", int'(bus.busy), 0);
            chk("start_conds", n_start, e.starts);
            chk("stop_conds", n_stop, e.stops);
            if (e.cmd == CMD_WRITE) begin
              chk("nack", int'(bus.nack), int'(e.nk));
              chk("scl_low_in_hold", int'(iclk), 0);
            end
            if (e.cmd == CMD_READ) chk("rd_data", int'(bus.rd_data), int'(e.rd));
            if (e.cmd == CMD_STOP) begin
              chk("idle_scl", int'(iclk), 1);
              chk("idle_sda", int'(sdata), 1);
            end
          end
        end
      end
      pdone = bus.done;
      perr = bus.err;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 50 * QDIV + 20) begin
      @(posedge clk);
      t++;
    end
    chk("completion_in_time", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // issue one command; the expectation comes from the command rules, not the RTL
  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic rn, input logic ack, input bit wait_done);
    exp_t e;
    logic legal;
    legal = owned || c == CMD_START;
    @(posedge clk); #1;
    e.is_err = !legal;
    e.cmd = c;
    e.rd = d;
    e.nk = !ack;
    e.acc = cyc;
    e.lat = !legal ? 1 : (c == CMD_START || c == CMD_STOP) ? 4 * QDIV + 1 : 36 * QDIV + 1;
    if (legal) begin
      e_rise += c == CMD_START ? (owned ? 1 : 0) : c == CMD_STOP ? 1 : 9;
      if (c == CMD_START) e_start++;
      if (c == CMD_STOP) e_stop++;
      owned = c != CMD_STOP;
      slv_mode = c == CMD_WRITE ? 1 : c == CMD_READ ? 2 : 0;
      slv_byte = d;
      slv_ack = ack;
      slv_rdn = rn;
      seq++;
    end
    e.starts = e_start;
    e.stops = e_stop;
    e.rises = e_rise;
    exp_q.push_back(e);
    bus.cmd_valid = 1;
    bus.cmd = c;
    bus.wr_data = d;
    bus.rd_nack = rn;
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    bus.wr_data = 8'($urandom);
    bus.rd_nack = 1'($urandom);
    if (wait_done) wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit, %0d/%0d passed so far", passes, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, nb;
    logic [7:0] d;
    bus.cmd_valid = 0;
    bus.cmd = 0;
    bus.wr_data = 0;
    bus.rd_nack = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_iclk", int'(iclk), 1);
    chk("rst_sda", int'(sdata), 1);
    chk("rst_ready", int'(bus.cmd_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_nack", int'(bus.nack), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    rst = 0;
    issue(CMD_START, 8'h00, 0, 0, 1);
    issue(CMD_WRITE, 8'hA0, 0, 1, 1);
    issue(CMD_STOP, 8'h00, 0, 0, 1);
    issue(CMD_START, 8'h00, 0, 0, 1);
    issue(CMD_WRITE, 8'h3C, 0, 0, 1);
    issue(CMD_STOP, 8'h00, 0, 0, 1);
    issue(CMD_START, 8'h00, 0, 0, 1);
    issue(CMD_WRITE, 8'hA1, 0, 1, 1);
    issue(CMD_READ, 8'h5A, 1, 0, 1);
    issue(CMD_STOP, 8'h00, 0, 0, 1);
    issue(CMD_START, 8'h00, 0, 0, 1);
    issue(CMD_WRITE, 8'hA0, 0, 1, 1);
    issue(CMD_START, 8'h00, 0, 0, 1);
    issue(CMD_READ, 8'($urandom), 0, 0, 1);
    issue(CMD_READ, 8'($urandom), 1, 0, 1);
    issue(CMD_STOP, 8'h00, 0, 0, 1);
    issue(CMD_WRITE, 8'h55, 0, 1, 1);
    issue(CMD_STOP, 8'h00, 0, 0, 1);
    issue(CMD_READ, 8'h12, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      issue(CMD_START, 8'h00, 0, 0, 1);
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        d = 8'($urandom);
        if ($urandom_range(0, 1) == 0) issue(CMD_WRITE, d, 0, $urandom_range(0, 3) != 0, 1);
        else issue(CMD_READ, d, j == nb - 1 ? 1'b1 : 1'($urandom), 0, 1);
        if ($urandom_range(0, 4) == 0) issue(CMD_START, 8'h00, 0, 0, 1);
      end
      issue(CMD_STOP, 8'h00, 0, 0, 1);
    end
    issue(CMD_START, 8'h00, 0, 0, 1);
    issue(CMD_WRITE, 8'hC3, 0, 1, 0);
    t = 0;
    while (rx_n < 5 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    chk("reached_bit4", int'(rx_n >= 5), 1);
    #2 rst = 1;
    #1;
    chk("abort_iclk", int'(iclk), 1);
    chk("abort_sda", int'(sdata), 1);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_ready", int'(bus.cmd_ready), 1);
    exp_q.delete();
    owned = 0;
    e_start = 0;
    e_stop = 0;
    e_rise = 0;
    slv_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    issue(CMD_START, 8'h00, 0, 0, 1);
    issue(CMD_WRITE, 8'h9E, 0, 1, 1);
    issue(CMD_STOP, 8'h00, 0, 0, 1);
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/iic_master.md
Name: iic_master

Overview:
- Parametrised byte-level I2C master; successor to the team's fixed write-only IIC block.
- Adds a programmable SCL rate, read transfers, slave ACK/NACK capture, master ACK/NACK on reads, repeated START and a command handshake.
- Sits between a controller FSM (e.g. EEPROM sequencer) and the board's SCL/SDA pins.

Parameters:
- QDIV, 125: system clocks per quarter SCL period; SCL = clk/(4*QDIV); legal range 2..65535.
- QW, 16: width of the quarter-period counter.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd  in  2  0=START, 1=WRITE, 2=READ, 3=STOP.
- wr_data  in  8  byte for WRITE, sampled at acceptance.
- rd_nack  in  1  READ only: 1 = master sends NACK (last byte), sampled at acceptance.
- rd_data  out  8  byte received by READ, valid when done=1.
- nack  out  1  WRITE only: sampled slave ACK bit (1 = NACK), valid when done=1.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse when an illegal command is rejected.
- busy  out  1  high from acceptance until done.
- iclk  out  1  SCL, push-pull, idles high.
- sdata  inout  1  SDA, open-drain: drives 0 or releases to z.

Behaviour:
- Reset: iclk=1, sdata released, cmd_ready=1, done=0, err=0, busy=0, nack=0, rd_data=0, FSM to IDLE, quarter counter 0. Reset mid-transfer aborts immediately; no STOP is generated.
- Quarter tick: counter counts 0..QDIV-1 while not IDLE/HOLD; a tick is issued at QDIV-1, then the counter wraps to 0. Counter is held at 0 in IDLE/HOLD.
- States:
  - IDLE: bus free.
  - HOLD: bus owned, SCL low.
  - START, WRITE, READ, STOP.
- cmd_ready=1 only in IDLE and HOLD; acceptance moves to the command's state with busy=1 in the next cycle.
- START, 4 quarters, from IDLE or HOLD (repeated start):
  - q0: SDA released, SCL low (SCL high if from IDLE).
  - q1: SCL high.
  - q2: SDA low.
  - q3: SCL low.
  - Then HOLD.
- Bit cell, 4 quarters:
  - q0: SCL low, SDA set.
  - q1: SCL high.
  - q2: SCL high; SDA sampled at the tick ending q2.
  - q3: SCL low.
- WRITE: 9 bit cells, MSB first. Bit 9 releases SDA; its sampled value goes to nack. Then HOLD.
- READ: 8 cells with SDA released, shifting MSB first into rd_data. Cell 9 drives rd_nack (0 drives low, 1 releases). Then HOLD.
- STOP, from HOLD:
  - q0: SDA low.
  - q1: SCL high.
  - q2: SDA released.
  - q3: idle.
  - Then IDLE.
- done: pulses in the cycle the FSM enters HOLD or IDLE. busy falls in the same cycle. rd_data and nack are updated in that cycle and held until the next completion.
- Illegal commands: WRITE/READ in IDLE, or START/STOP... (STOP in IDLE) -> err pulse one cycle after acceptance; no bus activity, state unchanged, no done. START in IDLE is legal.
- No clock stretching or arbitration: iclk is never read back.
- Simultaneous events: cmd_valid during busy is ignored. rst has priority over everything.
- Latency: START/STOP take 4*QDIV+1 cycles from acceptance to done; WRITE/READ take 36*QDIV+1.

Decomposition:
- Package iic_pkg:
  - Command encodings CMD_START/CMD_WRITE/CMD_READ/CMD_STOP.
  - One-hot state constants S_IDLE, S_HOLD, S_START, S_WRITE, S_READ, S_STOP.
  - Quarter indices.
- Sub-module iic_tick_gen (QDIV, QW): clk, rst, run in; tick out. Implements the quarter counter.
- Bit counter (0..8) and shift register stay in iic_master.

Test Plan:
- QDIV=4; START, WRITE 0xA0 with slave model ACK, STOP -> SDA falls while SCL high; SCL bits read 1,0,1,0,0,0,0,0; nack=0; three done pulses; START/STOP done at 17 cycles, WRITE done at 145 cycles; bus ends with iclk=1 and sdata=z.
- WRITE 0x3C with no slave present (SDA pulled up) -> nack=1 with done; state HOLD; cmd_ready=1.
- START, WRITE 0xA1, READ with rd_nack=1 and slave returning 0x5A, STOP -> rd_data=0x5A; 9th bit SDA released; stop condition observed.
- START, WRITE 0xA0, START (repeated), READ rd_nack=0 -> SDA rises with SCL low and falls with SCL high, without a STOP; 9th bit of the read is driven low.
- In IDLE, issue WRITE then STOP -> two err pulses, no SCL edges, done never asserted.
- Assert rst during bit 4 of a WRITE -> within the same cycle iclk=1, sdata=z, busy=0, cmd_ready=1; a following START works normally.
